// File: rtl/frame_buffer_if.sv
// Sample-in / frame-out bundle for frame_buffer.
// master is the producer plus reader side, slave is the buffer itself.
interface frame_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                         enable_i;
  logic signed [DATA_WIDTH-1:0] sample_i;
  logic                         sample_valid_i;
  logic                         start_o;
  logic signed [DATA_WIDTH-1:0] frame_sample_o;
  logic                         valid_to_read_o;
  logic                         rd_en_i;
  logic [ADDR_WIDTH-1:0]        frame_ptr_o;
  logic                         frame_done_o;
  logic [ADDR_WIDTH:0]          fill_o;
  logic                         overflow_o;

  modport master (
    output enable_i,
    output sample_i,
    output sample_valid_i,
    output rd_en_i,
    input  start_o,
    input  frame_sample_o,
    input  valid_to_read_o,
    input  frame_ptr_o,
    input  frame_done_o,
    input  fill_o,
    input  overflow_o
  );

  modport slave (
    input  enable_i,
    input  sample_i,
    input  sample_valid_i,
    input  rd_en_i,
    output start_o,
    output frame_sample_o,
    output valid_to_read_o,
    output frame_ptr_o,
    output frame_done_o,
    output fill_o,
    output overflow_o
  );
endinterface

// File: rtl/frame_buffer.sv
// Circular sample buffer that cuts overlapping frames of FRAME_LEN
// samples, hopping HOP_LEN per frame, served one sample per handshake.
module frame_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 306,
  parameter int HOP_LEN    = 102,
  parameter int BUF_DEPTH  = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic           clk,
  input  logic           rst,
  frame_buffer_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SERVE,
    FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] HOP_A = ADDR_WIDTH'(HOP_LEN);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   HOP_F = (ADDR_WIDTH + 1)'(HOP_LEN);
  localparam logic [ADDR_WIDTH:0]   ONE_F = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   FULL  = (ADDR_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0]   FLEN  = (ADDR_WIDTH + 1)'(FRAME_LEN);

  logic [DATA_WIDTH-1:0]        r_mem [BUF_DEPTH];
  state_t                       r_state;
  logic [ADDR_WIDTH-1:0]        r_wr_ptr;
  logic [ADDR_WIDTH-1:0]        r_base;
  logic [ADDR_WIDTH-1:0]        r_rd_cnt;
  logic [ADDR_WIDTH:0]          r_fill;
  logic signed [DATA_WIDTH-1:0] r_sample;
  logic                         r_valid;
  logic                         r_done;
  logic                         r_ovf;

  logic                  w_wr_en;
  logic                  w_start;
  logic                  w_hs;
  logic                  w_release;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH:0]   w_fill_next;

  // fill limit keeps the writer off the unreleased frame base
  assign w_wr_en     = bus.sample_valid_i && (r_fill != FULL);
  assign w_start     = (r_state == IDLE) && bus.enable_i
                       && (r_fill >= FLEN);
  assign w_hs        = r_valid && bus.rd_en_i;
  assign w_release   = (r_state == FINISH);
  assign w_next_addr = r_base + r_rd_cnt + ONE_A;

  always_comb begin
    w_fill_next = r_fill;
    if (w_wr_en)   w_fill_next = w_fill_next + ONE_F;
    if (w_release) w_fill_next = w_fill_next - HOP_F;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= bus.sample_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_base   <= '0;
      r_rd_cnt <= '0;
      r_fill   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_fill <= w_fill_next;
      r_done <= 1'b0;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ONE_A;
      if (bus.sample_valid_i && !w_wr_en) r_ovf <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_rd_cnt <= '0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_sample <= r_mem[r_base];
          r_valid  <= 1'b1;
          r_rd_cnt <= '0;
          r_state  <= SERVE;
        end
        SERVE: begin
          if (w_hs) begin
            if (r_rd_cnt == LAST) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_rd_cnt <= r_rd_cnt + ONE_A;
              r_sample <= r_mem[w_next_addr];
            end
          end
        end
        FINISH: begin
          r_base  <= r_base + HOP_A;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.start_o         = w_start;
  assign bus.frame_sample_o  = r_sample;
  assign bus.valid_to_read_o = r_valid;
  assign bus.frame_ptr_o     = r_rd_cnt;
  assign bus.frame_done_o    = r_done;
  assign bus.fill_o          = r_fill;
  assign bus.overflow_o      = r_ovf;
endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: directed phases with random data/reader
// timing, checked against a queue-based model of the stored window.
module tb_frame_buffer;
  localparam int DW    = 16;
  localparam int FL    = 306;
  localparam int HOP   = 102;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  frame_buffer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN(FL),
    .HOP_LEN(HOP),
    .BUF_DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // model: q holds every stored sample from the frame base onward
  logic signed [DW-1:0] q[$];
  bit m_ovf, m_busy, m_load, m_valid, m_done_due;
  int m_idx;
  int n_hs, n_done, n_start;
  int rd_mode;
  int cyc;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    bit exp_start;
    bit next_done;
    if (rst) begin
      q.delete();
      m_ovf      = 1'b0;
      m_busy     = 1'b0;
      m_load     = 1'b0;
      m_valid    = 1'b0;
      m_done_due = 1'b0;
      m_idx      = 0;
    end else begin
      exp_start = !m_busy && bus.enable_i && (q.size() >= FL);
      check("fill", bus.fill_o, q.size());
      check("overflow", bus.overflow_o, m_ovf);
      check("start", bus.start_o, exp_start);
      check("done", bus.frame_done_o, m_done_due);
      check("valid", bus.valid_to_read_o, m_valid);
      if (m_valid) begin
        check("ptr", bus.frame_ptr_o, m_idx);
        check("data", bus.frame_sample_o, q[m_idx]);
      end
      next_done = 1'b0;
      if (m_valid && bus.rd_en_i) begin
        n_hs++;
        if (m_idx == FL - 1) begin
          m_valid   = 1'b0;
          next_done = 1'b1;
        end else begin
          m_idx++;
        end
      end
      if (m_load) begin
        m_load  = 1'b0;
        m_valid = 1'b1;
        m_idx   = 0;
      end
      if (exp_start) begin
        m_busy = 1'b1;
        m_load = 1'b1;
        n_start++;
      end
      if (bus.sample_valid_i) begin
        if (q.size() < DEPTH) q.push_back(bus.sample_i);
        else m_ovf = 1'b1;
      end
      if (m_done_due) begin
        n_done++;
        repeat (HOP) void'(q.pop_front());
        m_busy = 1'b0;
      end
      m_done_due = next_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rd_mode)
      0:       bus.rd_en_i = 1'b1;
      1:       bus.rd_en_i = (cyc % 3 == 0);
      default: bus.rd_en_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_zero(string tag);
    check({tag, "_start"}, bus.start_o, 0);
    check({tag, "_sample"}, bus.frame_sample_o, 0);
    check({tag, "_valid"}, bus.valid_to_read_o, 0);
    check({tag, "_ptr"}, bus.frame_ptr_o, 0);
    check({tag, "_done"}, bus.frame_done_o, 0);
    check({tag, "_fill"}, bus.fill_o, 0);
    check({tag, "_ovf"}, bus.overflow_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero("rst");
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_seq(int n, int v0);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = DW'(v0 + i);
      tick();
    end
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic write_rand(int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = DW'($urandom);
      tick();
    end
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic wait_done(int target, int budget, string tag);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_done >= target, 1);
  endtask

  initial begin
    int hs0;
    int d0;
    int k;
    bus.enable_i       = 1'b0;
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    bus.rd_en_i        = 1'b0;
    rd_mode            = 0;
    cyc                = 0;
    n_hs               = 0;
    n_done             = 0;
    n_start            = 0;
    #2;
    check_zero("init");
    tick();
    tick();
    rst = 1'b0;

    // basic frame, then overlapping second frame
    bus.enable_i = 1'b1;
    write_seq(FL, 0);
    wait_done(1, 2000, "frame1_timeout");
    check("frame1_fill", bus.fill_o, 204);
    check("frame1_starts", n_start, 1);
    write_seq(HOP, FL);
    wait_done(2, 2000, "frame2_timeout");
    check("frame2_starts", n_start, 2);

    // reader stalls between handshakes
    rd_mode = 1;
    write_rand(HOP);
    wait_done(3, 3000, "stall_timeout");

    // overflow with starts blocked
    rd_mode = 0;
    do_reset();
    bus.enable_i = 1'b0;
    write_seq(DEPTH + 1, 0);
    tick();
    check("ovf_fill", bus.fill_o, DEPTH);
    check("ovf_flag", bus.overflow_o, 1);
    bus.enable_i = 1'b1;
    wait_done(n_done + 1, 2000, "ovf_frame_timeout");
    check("ovf_sticky", bus.overflow_o, 1);

    // continuous random traffic, base wraps past the buffer end
    do_reset();
    rd_mode = 2;
    d0 = n_done + 6;
    k  = 0;
    while (n_done < d0 && k < 10000) begin
      bus.sample_valid_i = ($urandom_range(0, 3) != 0);
      bus.sample_i       = DW'($urandom);
      tick();
      k++;
    end
    bus.sample_valid_i = 1'b0;
    check("wrap_frames", n_done >= d0, 1);

    // reset in the middle of a frame
    rd_mode = 0;
    do_reset();
    write_rand(FL);
    hs0 = n_hs;
    k   = 0;
    while (n_hs < hs0 + 100 && k < 500) begin
      tick();
      k++;
    end
    check("mid_hs_reached", n_hs >= hs0 + 100, 1);
    d0 = n_done;
    do_reset();
    repeat (3) tick();
    check("mid_no_done", n_done, d0);
    write_rand(FL);
    wait_done(d0 + 1, 2000, "post_rst_timeout");

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Producer-side counterpart of the windowing stage. Writes incoming PCM samples into a circular buffer and cuts them into overlapping frames of FRAME_LEN samples, advancing HOP_LEN samples per frame.
- Serves each frame, one sample per handshake, to the downstream reader (the Hamming window stage).
- Sits between the audio sample source and the MFCC windowing/FFT chain.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- FRAME_LEN, 306, samples per frame.
- HOP_LEN, 102, frame advance in samples (1 ≤ HOP_LEN ≤ FRAME_LEN).
- BUF_DEPTH, 512, circular buffer depth; power of two, ≥ FRAME_LEN + HOP_LEN.
- ADDR_WIDTH, 9, log2(BUF_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- enable_i  in  1  permits starting new frames; writes are accepted regardless.
- sample_i  in  DATA_WIDTH  signed input sample.
- sample_valid_i  in  1  write strobe for sample_i; no backpressure.
- start_o  out  1  one-cycle pulse when a frame begins.
- frame_sample_o  out  DATA_WIDTH  current frame sample, registered.
- valid_to_read_o  out  1  frame_sample_o holds a valid, unconsumed sample.
- rd_en_i  in  1  reader consumes frame_sample_o in any cycle where valid_to_read_o=1.
- frame_ptr_o  out  ADDR_WIDTH  index (0..FRAME_LEN-1) of the sample on frame_sample_o.
- frame_done_o  out  1  one-cycle pulse after the last sample of a frame is consumed.
- fill_o  out  ADDR_WIDTH+1  samples stored from the frame base to the write pointer.
- overflow_o  out  1  sticky; set when a sample is dropped.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, base_ptr, rd_cnt, fill and state are cleared to 0/IDLE.
  - All outputs are 0.
  - Buffer contents are don't-care.
  - Reset mid-frame abandons the frame; no frame_done_o is produced.
- Write side:
  - sample_valid_i=1 with fill<BUF_DEPTH: store at wr_ptr, wr_ptr++ (mod BUF_DEPTH), fill++.
  - sample_valid_i=1 with fill==BUF_DEPTH: drop the sample and set overflow_o (cleared only by rst).
- Fill update when a write and a hop release occur in the same cycle: fill_next = fill + 1 − HOP_LEN. The write is checked against the pre-release fill.
- IDLE:
  - If enable_i=1 and fill ≥ FRAME_LEN, pulse start_o, issue a synchronous buffer read at base_ptr, rd_cnt=0, go to LOAD.
  - A write in the same cycle is not counted toward this check.
- LOAD (1 cycle): frame_sample_o ← buf[base_ptr], valid_to_read_o=1, frame_ptr_o=0, go to SERVE.
  - valid_to_read_o therefore rises 2 cycles after start_o.
- SERVE:
  - Valid/ready handshake. While rd_en_i=0, frame_sample_o and frame_ptr_o hold.
  - Handshake with rd_cnt<FRAME_LEN-1: next sample buf[(base_ptr+rd_cnt+1) mod BUF_DEPTH] appears on the next cycle with valid_to_read_o still 1.
  - Full throughput: rd_en_i held high consumes one sample per cycle with no bubbles.
  - Handshake on rd_cnt=FRAME_LEN-1: valid_to_read_o=0 next cycle, go to FINISH.
- FINISH (1 cycle):
  - Pulse frame_done_o.
  - base_ptr += HOP_LEN (mod BUF_DEPTH); fill −= HOP_LEN.
  - Return to IDLE. The next frame may start the cycle after.
- Address arithmetic is unsigned and wraps mod BUF_DEPTH; frames spanning the buffer end read contiguously across the wrap.
- rd_en_i while valid_to_read_o=0 is ignored.
- enable_i deassertion mid-frame does not abort the frame; it only blocks the next start.
- Samples written during SERVE are never overwritten, because the fill limit protects the frame base.

Test Plan:
1. Basic frame: enable_i=1, write 306 samples with values 0..305, rd_en_i held 1.
   - start_o pulses once; 306 handshakes carry data 0..305 with frame_ptr_o 0..305, no gaps.
   - frame_done_o pulses; fill_o=204 afterwards.
2. Overlap: continue from test 1 and write 102 more samples (306..407).
   - Second start_o fires; frame data is 102..407.
3. Reader stall: assert rd_en_i only every 3rd cycle.
   - frame_sample_o and frame_ptr_o stay stable between handshakes; the sequence is unchanged, with no duplicates or skips.
4. Overflow: enable_i=0, write 513 samples.
   - fill_o=512 and overflow_o=1 after the 513th write.
   - Set enable_i=1: the frame reads samples 0..305; overflow_o stays 1.
5. Wrap-around: run 3 frames continuously (writes interleaved with reads).
   - The third frame (base 204) spans indices 204..509, then a later frame crosses 511→0; data stays contiguous.
6. Reset mid-frame: assert rst after 100 handshakes.
   - All outputs are 0 immediately, no frame_done_o.
   - A fresh 306-sample write produces a frame starting at value written first after reset.
